// File: rtl/fp_norm_round_pack.sv
// Normalise / round-to-nearest-even / pack back end of the single-precision adder.
// Define FP_NORM_LZC_EN for a single-cycle leading-zero left shift instead of the 1-bit iterative shifter.
module fp_norm_round_pack #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int SUM_W  = FRAC_W + 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SUM_W-1:0]        sum,
  input  logic [EXP_W-1:0]        exp_r,
  input  logic                    sign_r,
  input  logic                    complement,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    ovf,
  output logic                    inexact
);

  typedef enum logic [2:0] {IDLE, NORM, ROUND, PACK, OUT} state_t;

  localparam logic signed [EXP_W+1:0] E_ONE = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] E_MAX = (EXP_W+2)'((1 << EXP_W) - 1);

  state_t                    state_q, state_d;
  logic [SUM_W-1:0]          m_q, m_d;
  logic signed [EXP_W+1:0]   e_q, e_d;
  logic                      s_q, s_d;
  logic                      inx_q, inx_d;
  logic [EXP_W+FRAC_W:0]     result_q, result_d;
  logic                      ovf_q, ovf_d;
  logic                      inexact_q, inexact_d;
  logic                      out_valid_q, out_valid_d;
  logic [SUM_W-4:0]          m_up;
`ifdef FP_NORM_LZC_EN
  int                        lz_n;
  int                        sh_n;
`endif

  // Round half to even on the guard/round/sticky bits below the kept lsb m[3].
  function automatic logic round_up(input logic [SUM_W-1:0] m);
    return m[2] & (m[1] | m[0] | m[3]);
  endfunction

`ifdef FP_NORM_LZC_EN
  function automatic int lzc(input logic [SUM_W-2:0] v);
    int n;
    n = SUM_W - 1;
    for (int i = 0; i < SUM_W - 1; i++) begin
      if (v[i]) n = SUM_W - 2 - i;
    end
    return n;
  endfunction
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign inexact   = inexact_q;

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    e_d         = e_q;
    s_d         = s_q;
    inx_d       = inx_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    inexact_d   = inexact_q;
    out_valid_d = out_valid_q;
    m_up        = m_q[SUM_W-1:3] + (SUM_W-3)'(1);
`ifdef FP_NORM_LZC_EN
    lz_n        = lzc(m_q[SUM_W-2:0]);
    sh_n        = (lz_n < (int'(e_q) - 1)) ? lz_n : (int'(e_q) - 1);
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = complement ? (~sum + SUM_W'(1)) : sum;
          e_d     = $signed({2'b00, exp_r});
          s_d     = sign_r;
          inx_d   = 1'b0;
          state_d = NORM;
        end
      end
      NORM: begin
        if (m_q == '0) begin
          // Exact cancellation always yields +0.
          e_d     = '0;
          s_d     = 1'b0;
          state_d = PACK;
        end else if (m_q[SUM_W-1]) begin
          m_d = {1'b0, m_q[SUM_W-1:2], m_q[1] | m_q[0]};
          e_d = e_q + E_ONE;
        end else if (!m_q[SUM_W-2] && (e_q > E_ONE)) begin
`ifdef FP_NORM_LZC_EN
          m_d     = m_q << sh_n;
          e_d     = e_q - (EXP_W+2)'(sh_n);
          state_d = ROUND;
`else
          m_d = {m_q[SUM_W-2:0], 1'b0};
          e_d = e_q - E_ONE;
`endif
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        inx_d   = inx_q | (|m_q[2:0]);
        state_d = PACK;
        if (round_up(m_q)) begin
          m_d = {m_up, m_q[2:0]};
          // Mantissa overflowed into the carry bit: one more right shift needed.
          if (m_up[SUM_W-4]) state_d = NORM;
        end
      end
      PACK: begin
        if (e_q >= E_MAX) begin
          result_d = {s_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          ovf_d    = 1'b1;
        end else if (!m_q[SUM_W-2]) begin
          result_d = {s_q, {EXP_W{1'b0}}, m_q[SUM_W-3:3]};
          ovf_d    = 1'b0;
        end else begin
          result_d = {s_q, e_q[EXP_W-1:0], m_q[SUM_W-3:3]};
          ovf_d    = 1'b0;
        end
        inexact_d   = inx_q;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      m_q         <= '0;
      e_q         <= '0;
      s_q         <= 1'b0;
      inx_q       <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      inexact_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      e_q         <= e_d;
      s_q         <= s_d;
      inx_q       <= inx_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      inexact_q   <= inexact_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fp_norm_round_pack.sv
// Directed bench for fp_norm_round_pack: hand-computed IEEE-754 results, flags and latencies.
module tb_fp_norm_round_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] sum;
  logic [7:0]  exp_r;
  logic        sign_r;
  logic        complement;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        inexact;

  int total = 0;
  int bad   = 0;
  int lat;

  always #5 clk = ~clk;

  fp_norm_round_pack dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum        (sum),
    .exp_r      (exp_r),
    .sign_r     (sign_r),
    .complement (complement),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .ovf        (ovf),
    .inexact    (inexact)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [27:0] s, input logic [7:0] e, input logic sg, input logic cm);
    @(negedge clk);
    chk("in_ready_before_issue", 32'(in_ready), 32'd1);
    sum        = s;
    exp_r      = e;
    sign_r     = sg;
    complement = cm;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
  endtask

  // Latency counts clock edges after the accepting edge until out_valid is seen.
  task automatic wait_out(output int l);
    l = 0;
    while (out_valid !== 1'b1 && l < 64) begin
      @(posedge clk);
      #1;
      l++;
    end
    if (l >= 64) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic xact(input string tag, input logic [27:0] s, input logic [7:0] e,
                      input logic sg, input logic cm, input logic [31:0] exp_res,
                      input logic exp_ovf, input logic exp_inx, input int exp_lat);
    int l;
    issue(s, e, sg, cm);
    wait_out(l);
    chk({tag, "_result"},  result,        exp_res);
    chk({tag, "_ovf"},     32'(ovf),      32'(exp_ovf));
    chk({tag, "_inexact"}, 32'(inexact),  32'(exp_inx));
    chk({tag, "_latency"}, 32'(l),        32'(exp_lat));
    @(posedge clk);
    #1;
    chk({tag, "_released"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    sum        = '0;
    exp_r      = '0;
    sign_r     = 1'b0;
    complement = 1'b0;
    #12;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result",    result,         32'h0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    chk("rst_inexact",   32'(inexact),   32'd0);
    @(negedge clk);
    reset = 1'b0;

    xact("add_1p05",    28'h4333333, 8'd127, 1'b0, 1'b0, 32'h3F866666, 1'b0, 1'b1, 3);
    xact("add_1p1",     28'h8000000, 8'd127, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 4);
    xact("overflow",    28'h8000000, 8'd254, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0, 4);
    // Zero skips ROUND: NORM then PACK.
    xact("zero_neg",    28'h0000000, 8'd127, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b0, 2);
    xact("tie_carry",   28'h7FFFFFC, 8'd127, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b1, 6);
    xact("tie_even",    28'h7FFFFF4, 8'd127, 1'b0, 1'b0, 32'h3FFFFFFE, 1'b0, 1'b1, 3);
    xact("lshift_neg",  28'hF800000, 8'd127, 1'b1, 1'b1, 32'hBE000000, 1'b0, 1'b0, 6);
    xact("denormal",    28'h0400000, 8'd3,   1'b0, 1'b0, 32'h00200000, 1'b0, 1'b0, 5);
    xact("long_norm",   28'h0000001, 8'd200, 1'b0, 1'b0, 32'h57000000, 1'b0, 1'b0, 29);

    // Output backpressure: result held, no new input accepted.
    out_ready = 1'b0;
    issue(28'h4333333, 8'd127, 1'b0, 1'b0);
    wait_out(lat);
    chk("bp_first_result", result, 32'h3F866666);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_result",    result,          32'h3F866666);
      chk("bp_out_valid", 32'(out_valid),  32'd1);
      chk("bp_in_ready",  32'(in_ready),   32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready),  32'd1);

    // Reset while NORM is still shifting: nothing must be emitted.
    issue(28'hF800000, 8'd127, 1'b1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result",    result,         32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_quiet", 32'(out_valid), 32'd0);
    end

    xact("after_rst",   28'h8000000, 8'd127, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
